// File: rtl/vco_adc_unary_dac.sv
// vco_adc_unary_dac: converts a clamped unsigned code into unary element
// drives for a unit-cell feedback DAC, with true and complement outputs.
// With DAC_DWA_EN defined, data-weighted averaging rotates the start element
// so that element mismatch is first-order shaped; otherwise the mapping is a
// plain thermometer code and ptr stays at 0.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   din     unsigned code, meaningful range 0..N_ELEM (larger values clamp)
//   din_en  qualifies din; when low every register holds
//   dout    element enables, bit k drives cell k
//   dout_b  registered bitwise complement of dout
//   ptr     DWA start pointer
//   sat     set for the update whose din exceeded N_ELEM
module vco_adc_unary_dac #(
  parameter int unsigned N_ELEM = 32,
  parameter int unsigned W_IN   = 6,
  parameter int unsigned PTR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_IN-1:0]   din,
  input  logic              din_en,
  output logic [N_ELEM-1:0] dout,
  output logic [N_ELEM-1:0] dout_b,
  output logic [PTR_W-1:0]  ptr,
  output logic              sat
);

  // One extra bit so that n = N_ELEM is representable.
  localparam int unsigned NW = PTR_W + 1;

  logic [NW-1:0]     n_c;
  logic              sat_c;
  logic [PTR_W-1:0]  base_c;
  logic [PTR_W-1:0]  ptr_next_c;
  logic [N_ELEM-1:0] mask_c;

  // Clamp, start pointer, and per-bit selection of the contiguous run.
  always_comb begin
    sat_c = (din > W_IN'(N_ELEM));
    n_c   = sat_c ? NW'(N_ELEM) : NW'(din);
`ifdef DAC_DWA_EN
    base_c     = ptr;
    // ptr + n never exceeds 2*N_ELEM-1, so NW bits hold the sum before the wrap.
    ptr_next_c = PTR_W'({1'b0, ptr} + n_c);
`else
    base_c     = '0;
    ptr_next_c = '0;
`endif
    mask_c = '0;
    for (int k = 0; k < N_ELEM; k++) begin
      // Offset of bit k from the start wraps modulo N_ELEM in PTR_W bits.
      mask_c[k] = ({1'b0, PTR_W'(PTR_W'(k) - base_c)} < n_c);
    end
  end

  // Single registered stage; reset wins over din_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout   <= '0;
      dout_b <= '1;
      ptr    <= '0;
      sat    <= 1'b0;
    end else if (din_en) begin
      dout   <= mask_c;
      dout_b <= ~mask_c;
      ptr    <= ptr_next_c;
      sat    <= sat_c;
    end
  end

endmodule

// File: tb/tb_vco_adc_unary_dac.sv
// Self-checking bench for vco_adc_unary_dac: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_vco_adc_unary_dac;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  din;
  logic        din_en;
  logic [31:0] dout;
  logic [31:0] dout_b;
  logic [4:0]  ptr;
  logic        sat;

  int checks = 0;
  int errors = 0;

  vco_adc_unary_dac dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .din_en (din_en),
    .dout   (dout),
    .dout_b (dout_b),
    .ptr    (ptr),
    .sat    (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs seen by the DUT at each rising edge.
  logic [5:0] s_din;
  logic       s_en;
  logic       s_rst;
  always @(posedge clk) begin
    s_din <= din;
    s_en  <= din_en;
    s_rst <= rst;
  end

  // Behavioural model advanced and compared once per cycle on the falling edge.
  initial begin : model
    logic [31:0] m_dout;
    int          m_ptr;
    int          m_n;
    logic        m_sat;
    bit          valid;
    valid = 0; m_dout = '0; m_ptr = 0; m_n = 0; m_sat = 0;
    forever begin
      @(negedge clk);
      if (s_rst === 1'b1) begin
        valid = 1; m_dout = '0; m_ptr = 0; m_n = 0; m_sat = 0;
      end else if (valid && s_en === 1'b1) begin
        m_n   = (int'(s_din) > 32) ? 32 : int'(s_din);
        m_sat = (int'(s_din) > 32);
        m_dout = '0;
        for (int i = 0; i < m_n; i++) begin
`ifdef DAC_DWA_EN
          m_dout[(m_ptr + i) % 32] = 1'b1;
`else
          m_dout[i] = 1'b1;
`endif
        end
`ifdef DAC_DWA_EN
        m_ptr = (m_ptr + m_n) % 32;
`endif
      end
      if (valid) begin
        chk("model_dout", dout, m_dout);
        chk("model_dout_b", dout_b, ~m_dout);
        chk("model_ptr", 32'(ptr), 32'(m_ptr));
        chk("model_sat", 32'(sat), 32'(m_sat));
        chk("model_popcount", 32'($countones(dout)), 32'(m_n));
      end
    end
  end

  // Apply one set of inputs for one edge; returns shortly after that edge.
  task automatic cyc(input logic [5:0] d, input logic en, input logic r);
    din = d; din_en = en; rst = r;
    @(posedge clk);
    #2;
  endtask

  logic [31:0] hold_dout;

  initial begin
    din = '0; din_en = 1'b0; rst = 1'b1;
    cyc(6'd0, 1'b0, 1'b1);
    cyc(6'd0, 1'b0, 1'b1);
    chk("reset_dout", dout, 32'h0000_0000);
    chk("reset_dout_b", dout_b, 32'hFFFF_FFFF);
    chk("reset_ptr", 32'(ptr), 32'd0);
    chk("reset_sat", 32'(sat), 32'd0);

`ifdef DAC_DWA_EN
    cyc(6'd5, 1'b1, 1'b0);
    chk("d5_dout", dout, 32'h0000_001F);
    chk("d5_dout_b", dout_b, 32'hFFFF_FFE0);
    chk("d5_ptr", 32'(ptr), 32'd5);
    cyc(6'd30, 1'b1, 1'b0);
    chk("d30_dout", dout, 32'hFFFF_FFE7);
    chk("d30_ptr", 32'(ptr), 32'd3);
    cyc(6'd0, 1'b1, 1'b0);
    chk("d0_dout", dout, 32'h0000_0000);
    chk("d0_ptr", 32'(ptr), 32'd3);
    cyc(6'd32, 1'b1, 1'b0);
    chk("d32_dout", dout, 32'hFFFF_FFFF);
    chk("d32_ptr", 32'(ptr), 32'd3);
    cyc(6'd45, 1'b1, 1'b0);
    chk("d45_dout", dout, 32'hFFFF_FFFF);
    chk("d45_sat", 32'(sat), 32'd1);
    chk("d45_ptr", 32'(ptr), 32'd3);
    cyc(6'd1, 1'b1, 1'b0);
    chk("d1_dout", dout, 32'h0000_0008);
    chk("d1_sat", 32'(sat), 32'd0);
    chk("d1_ptr", 32'(ptr), 32'd4);
    cyc(6'd6, 1'b1, 1'b0);
    chk("d6_ptr", 32'(ptr), 32'd10);
    hold_dout = 32'h0000_03F0;
`else
    cyc(6'd5, 1'b1, 1'b0);
    chk("t5_dout", dout, 32'h0000_001F);
    chk("t5_ptr", 32'(ptr), 32'd0);
    cyc(6'd30, 1'b1, 1'b0);
    chk("t30_dout", dout, 32'h3FFF_FFFF);
    chk("t30_dout_b", dout_b, 32'hC000_0000);
    chk("t30_ptr", 32'(ptr), 32'd0);
    cyc(6'd1, 1'b1, 1'b0);
    chk("t1_dout", dout, 32'h0000_0001);
    chk("t1_ptr", 32'(ptr), 32'd0);
    cyc(6'd45, 1'b1, 1'b0);
    chk("t45_dout", dout, 32'hFFFF_FFFF);
    chk("t45_sat", 32'(sat), 32'd1);
    cyc(6'd6, 1'b1, 1'b0);
    chk("t6_sat", 32'(sat), 32'd0);
    hold_dout = 32'h0000_003F;
`endif

    // Hold with din toggling: everything frozen.
    for (int i = 0; i < 4; i++) begin
      cyc((i % 2 == 0) ? 6'd63 : 6'd17, 1'b0, 1'b0);
      chk("hold_dout", dout, hold_dout);
      chk("hold_sat", 32'(sat), 32'd0);
`ifdef DAC_DWA_EN
      chk("hold_ptr", 32'(ptr), 32'd10);
`endif
    end
    cyc(6'd40, 1'b0, 1'b1);
    chk("midrst_dout", dout, 32'h0000_0000);
    chk("midrst_ptr", 32'(ptr), 32'd0);
    cyc(6'd2, 1'b1, 1'b0);
    chk("post_rst_dout", dout, 32'h0000_0003);

`ifdef DAC_DWA_EN
    // ptr_old + n == N_ELEM exactly: run ends at bit 31, pointer wraps to 0.
    cyc(6'd18, 1'b1, 1'b0);
    chk("edge_pre_ptr", 32'(ptr), 32'd20);
    cyc(6'd12, 1'b1, 1'b0);
    chk("edge_dout", dout, 32'hFFF0_0000);
    chk("edge_ptr", 32'(ptr), 32'd0);
`endif

    // Randomized run, checked by the model every cycle.
    for (int i = 0; i < 10000; i++) begin
      cyc(6'($urandom_range(0, 63)), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 499) == 0));
    end
    cyc(6'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vco_adc_unary_dac.md
Name: vco_adc_unary_dac

Overview:
- Return-direction counterpart of the 32-phase VCO ADC path.
- Converts a 6-bit code into 32 unary element drives, with true and complement outputs.
- Drives a 32-element unit-cell DAC in the feedback path, using the same 32-wide true/complement bus convention as the sampler outputs.
- Data-weighted averaging (DWA) rotates element usage so that element mismatch becomes first-order shaped noise.

Parameters:
- N_ELEM, 32, number of unary elements; must be a power of two, 2..64.
- W_IN, 6, input code width; must satisfy 2^W_IN > N_ELEM.
- PTR_W, 5, pointer width; equals log2(N_ELEM).

Ports:
- clk  input  1  sole clock; rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- din  input  W_IN  unsigned code; meaningful range 0..N_ELEM.
- din_en  input  1  qualifies din; when low, all state and outputs hold.
- dout  output  N_ELEM  element enables; bit k drives cell k.
- dout_b  output  N_ELEM  bitwise complement of dout; registered, never combinational.
- ptr  output  PTR_W  current DWA start pointer (registered).
- sat  output  1  high for one update when din exceeded N_ELEM.

Behaviour:
- Reset (rst=1 at a clk edge), takes priority over din_en:
  - dout=0, dout_b=all ones, ptr=0, sat=0.
- Clamp: n = min(din, N_ELEM).
  - Any din > N_ELEM (33..63 at defaults) yields n=N_ELEM and sets sat=1 for that update.
  - Otherwise sat=0 on that update.
- Latency: one cycle. din sampled at edge t (din_en=1) appears on dout/dout_b/sat at edge t; visible until the next update.
- Selection with rotation:
  - dout bit k = 1 iff ((k - ptr_old) mod N_ELEM) < n.
  - ptr_old is the pointer value before this edge.
  - Set bits are contiguous from ptr_old upward, wrapping from bit N_ELEM-1 to bit 0.
- Pointer update: ptr <= (ptr_old + n) mod N_ELEM, on the same edge as dout.
- Boundary cases:
  - n=0: dout=0, ptr unchanged.
  - n=N_ELEM: dout=all ones, ptr unchanged (full wrap).
  - ptr_old + n = N_ELEM exactly: ptr becomes 0; the selection ends at bit N_ELEM-1 with no wrap.
- din_en=0: dout, dout_b, ptr and sat all hold their previous values; no update.
- rst asserted mid-stream: the next edge forces the reset values regardless of din/din_en; the first update after reset starts from ptr=0.
- Output invariant on every edge: dout_b == ~dout; popcount(dout) == n of the last update.
- Implementation: a single registered stage with no internal FSM beyond the pointer register. Mask generation may be a barrel rotate of a thermometer code or a comparison per bit; both must be cycle-exact to the rule above.

Optional Feature:
Macro DAC_DWA_EN.
- Defined: rotating DWA behaviour exactly as described in Behaviour.
- Undefined:
  - Plain thermometer: dout bit k = 1 iff k < n.
  - ptr is tied to 0 permanently.
  - Clamp, sat, latency, din_en hold and reset behaviour are unchanged.

Test Plan:
- Reset, then din_en=1 with din=5 at defaults -> next edge dout=0x0000001F, dout_b=0xFFFFFFE0, ptr=5, sat=0.
- Continue with din=30 -> dout bits 5..31 and 0..2 set (0xFFFFFFE7), ptr=3 (35 mod 32).
- Apply din=0 from ptr=3 -> dout=0, ptr stays 3. Then din=32 -> dout=0xFFFFFFFF, ptr stays 3.
- Apply din=45 from ptr=3 -> clamped to 32: dout=0xFFFFFFFF, sat=1, ptr=3. Next din=1 -> dout=0x00000008, sat=0, ptr=4.
- Reach ptr=10, then hold din_en=0 for 4 cycles while din toggles -> dout/ptr/sat frozen. Assert rst for one edge during the hold -> dout=0, ptr=0. Then din=2 -> dout=0x00000003.
- Build without DAC_DWA_EN; apply din sequence 5, 30, 1 -> dout=0x0000001F, 0x3FFFFFFF, 0x00000001; ptr=0 throughout.
- Random runs of 10k codes in 0..63, checked against a reference model: dout_b==~dout, popcount(dout)==min(din,32), ptr equals the running sum mod 32 (DWA build).
